// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG collector and its debiaser.
package trng_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        COLLECT,
        FULL,
        FAIL
    } trng_state_e;

    localparam int REP_LIMIT_DEFAULT = 32;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs consecutive input bits and emits the first bit of
// each unequal pair; equal pairs are silently dropped.
module trng_vn_debias (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic in_valid,
    input  logic in_bit,
    output logic out_valid,
    output logic out_bit
);

    logic have_first;
    logic first_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_first <= 1'b0;
            first_bit  <= 1'b0;
        end else if (clear) begin
            have_first <= 1'b0;
        end else if (in_valid) begin
            if (have_first) begin
                have_first <= 1'b0;
            end else begin
                have_first <= 1'b1;
                first_bit  <= in_bit;
            end
        end
    end

    // Output is combinational so the accepted bit lands on the same edge as the second sample.
    assign out_valid = in_valid && have_first && !clear && (first_bit != in_bit);
    assign out_bit   = first_bit;

endmodule

// File: rtl/trng_collector.sv
// Ring-oscillator TRNG front end: synchronise and combine raw bits, optionally
// debias, run a repetition-count health test and pack bits into words.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int NUM_SOURCES   = 4,
    parameter int DEBIAS        = 1,
    parameter int WARMUP_CYCLES = 16,
    parameter int REP_LIMIT     = REP_LIMIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_SOURCES-1:0] raw_bits,
    output logic                   trng_en,
    output logic [WIDTH-1:0]       word_data,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   health_fail
);

    localparam int BW = $clog2(WIDTH);
    localparam int WW = $clog2(WARMUP_CYCLES);
    localparam int RW = $clog2(REP_LIMIT + 1);

    trng_state_e            state;
    logic [NUM_SOURCES-1:0] sync1;
    logic [NUM_SOURCES-1:0] sync2;
    logic [WW-1:0]          warm_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [RW-1:0]          rep_cnt;
    logic [RW-1:0]          rep_next;
    logic                   prev_sample;
    logic [WIDTH-1:0]       shift_reg;
    logic [WIDTH-1:0]       next_shift;
    logic                   sample;
    logic                   consume;
    logic                   rep_trip;
    logic                   db_valid;
    logic                   db_bit;
    logic                   acc_valid;
    logic                   acc_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_bits;
            sync2 <= sync1;
        end
    end

    assign sample  = ^sync2;
    assign consume = (state == COLLECT);

    trng_vn_debias u_debias (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state != COLLECT),
        .in_valid  (consume),
        .in_bit    (sample),
        .out_valid (db_valid),
        .out_bit   (db_bit)
    );

    always_comb begin
        acc_valid = consume;
        acc_bit   = sample;
        if (DEBIAS != 0) begin
            acc_valid = db_valid;
            acc_bit   = db_bit;
        end
    end

    assign next_shift = {shift_reg[WIDTH-2:0], acc_bit};

    // rep_cnt of zero marks "no sample yet since entering COLLECT".
    always_comb begin
        rep_next = rep_cnt;
        if (rep_cnt == '0 || sample != prev_sample) begin
            rep_next = RW'(1);
        end else if (rep_cnt != RW'(REP_LIMIT)) begin
            rep_next = rep_cnt + RW'(1);
        end
    end

    assign rep_trip = consume && (rep_next == RW'(REP_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            trng_en     <= 1'b0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            health_fail <= 1'b0;
            warm_cnt    <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            prev_sample <= 1'b0;
            shift_reg   <= '0;
        end else if (state != IDLE && !enable) begin
            state       <= IDLE;
            trng_en     <= 1'b0;
            word_valid  <= 1'b0;
            health_fail <= 1'b0;
            warm_cnt    <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            shift_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= WARMUP;
                        trng_en   <= 1'b1;
                        warm_cnt  <= '0;
                        bit_cnt   <= '0;
                        rep_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                WARMUP: begin
                    if (warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
                        state   <= COLLECT;
                        rep_cnt <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + WW'(1);
                    end
                end
                COLLECT: begin
                    rep_cnt     <= rep_next;
                    prev_sample <= sample;
                    // A health trip overrides a word that would complete on the same edge.
                    if (rep_trip) begin
                        state       <= FAIL;
                        health_fail <= 1'b1;
                        trng_en     <= 1'b0;
                        word_valid  <= 1'b0;
                    end else if (acc_valid) begin
                        shift_reg <= next_shift;
                        if (bit_cnt == BW'(WIDTH - 1)) begin
                            word_data  <= next_shift;
                            word_valid <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= FULL;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                FULL: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        bit_cnt    <= '0;
                        rep_cnt    <= '0;
                        shift_reg  <= '0;
                        state      <= COLLECT;
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state   <= IDLE;
                    trng_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: one bypass instance and one debiasing instance.
module tb_trng_collector;

    logic       clk;
    logic       rst_n;

    logic       en0, rdy0, trng_en0, valid0, hf0;
    logic [3:0] raw0;
    logic [7:0] data0;

    logic       en1, rdy1, trng_en1, valid1, hf1;
    logic [3:0] raw1;
    logic [7:0] data1;

    int checks;
    int failures;

    logic [7:0]  w1, w2, w3, w4;
    logic [19:0] db_stream;

    trng_collector #(
        .WIDTH(8), .NUM_SOURCES(4), .DEBIAS(0), .WARMUP_CYCLES(4), .REP_LIMIT(4)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .raw_bits(raw0), .trng_en(trng_en0),
        .word_data(data0), .word_valid(valid0), .word_ready(rdy0), .health_fail(hf0)
    );

    trng_collector #(
        .WIDTH(8), .NUM_SOURCES(4), .DEBIAS(1), .WARMUP_CYCLES(4), .REP_LIMIT(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .raw_bits(raw1), .trng_en(trng_en1),
        .word_data(data1), .word_valid(valid1), .word_ready(rdy1), .health_fail(hf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the bypass instance for one clock edge.
    task automatic apply_stimulus(input logic [3:0] r, input logic e, input logic rd);
        raw0 = r;
        en0  = e;
        rdy0 = rd;
        tick();
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        w1        = 8'hAA;
        w2        = 8'h36;
        w3        = 8'hC9;
        w4        = 8'hE3;
        db_stream = 20'h63969;
        rst_n = 1'b0;
        raw0 = '0; en0 = 1'b0; rdy0 = 1'b0;
        raw1 = '0; en1 = 1'b0; rdy1 = 1'b0;
        tick();
        tick();
        check_output("reset_trng_en", trng_en0, 0);
        check_output("reset_word_data", data0, 0);
        check_output("reset_word_valid", valid0, 0);
        check_output("reset_health_fail", hf0, 0);
        check_output("reset_dut1_valid", valid1, 0);
        rst_n = 1'b1;

        // Bypass word AA: samples consumed from k+5, raw leads by two edges.
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("warmup_trng_en", trng_en0, 1);
        for (int i = 0; i <= 10; i++) begin
            apply_stimulus((i >= 2 && i <= 9) ? {3'b000, w1[9-i]} : 4'b0000, 1'b1, 1'b0);
        end
        check_output("w1_not_early", valid0, 0);
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("w1_valid", valid0, 1);
        check_output("w1_data", data0, 32'hAA);

        // Hold FULL with ready low; preload the next word's first sample.
        for (int t = 0; t < 5; t++) begin
            apply_stimulus((t == 4) ? {3'b000, w2[7]} : 4'b0000, 1'b1, 1'b0);
            check_output("hold_valid", valid0, 1);
            check_output("hold_data", data0, 32'hAA);
        end
        apply_stimulus({3'b000, w2[6]}, 1'b1, 1'b1);
        check_output("handshake_clears_valid", valid0, 0);
        for (int u = 1; u <= 7; u++) begin
            apply_stimulus((u <= 6) ? {3'b000, w2[6-u]} : 4'b0000, 1'b1, 1'b0);
        end
        check_output("w2_not_early", valid0, 0);
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("w2_valid", valid0, 1);
        check_output("w2_data", data0, 32'h36);

        // Handshake, five bits, then drop enable mid-word.
        apply_stimulus(4'b0001, 1'b1, 1'b1);
        for (int u = 1; u <= 5; u++) begin
            apply_stimulus({3'b000, u[0] ? 1'b0 : 1'b1}, 1'b1, 1'b0);
        end
        apply_stimulus(4'b0000, 1'b0, 1'b0);
        check_output("drop_trng_en", trng_en0, 0);
        check_output("drop_valid", valid0, 0);
        check_output("drop_data_retained", data0, 32'h36);

        // Re-enable with three active sources; XOR of the fixed two is zero.
        apply_stimulus(4'b0110, 1'b1, 1'b0);
        check_output("reenable_trng_en", trng_en0, 1);
        for (int i = 0; i <= 10; i++) begin
            apply_stimulus((i >= 2 && i <= 9) ? {3'b011, w3[9-i]} : 4'b0110, 1'b1, 1'b0);
        end
        check_output("w3_full_warmup", valid0, 0);
        apply_stimulus(4'b0110, 1'b1, 1'b0);
        check_output("w3_valid", valid0, 1);
        check_output("w3_data", data0, 32'hC9);

        apply_stimulus(4'b0000, 1'b0, 1'b1);
        check_output("hs_and_disable_valid", valid0, 0);
        check_output("hs_and_disable_trng_en", trng_en0, 0);
        check_output("hs_and_disable_data", data0, 32'hC9);

        // Runs of exactly REP_LIMIT-1 must not trip.
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            apply_stimulus((i >= 2 && i <= 9) ? {3'b000, w4[9-i]} : 4'b0000, 1'b1, 1'b0);
        end
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        check_output("w4_valid", valid0, 1);
        check_output("w4_data", data0, 32'hE3);
        check_output("w4_no_health_fail", hf0, 0);
        apply_stimulus(4'b0000, 1'b0, 1'b0);
        check_output("full_disable_valid", valid0, 0);

        // Stuck-at-1 source: trips on the fourth collected sample (edge k+8).
        apply_stimulus(4'b0001, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            apply_stimulus(4'b0001, 1'b1, 1'b0);
        end
        check_output("stuck_pre_trip_hf", hf0, 0);
        check_output("stuck_pre_trip_en", trng_en0, 1);
        apply_stimulus(4'b0001, 1'b1, 1'b0);
        check_output("stuck_trip_hf", hf0, 1);
        check_output("stuck_trip_en", trng_en0, 0);
        check_output("stuck_trip_valid", valid0, 0);
        apply_stimulus(4'b0001, 1'b1, 1'b0);
        apply_stimulus(4'b0001, 1'b1, 1'b0);
        check_output("fail_held", hf0, 1);
        apply_stimulus(4'b0001, 1'b0, 1'b0);
        check_output("fail_cleared_by_disable", hf0, 0);
        check_output("fail_idle_trng_en", trng_en0, 0);

        // Trip again and leave the bypass instance in FAIL.
        for (int i = 0; i <= 8; i++) begin
            apply_stimulus(4'b0001, 1'b1, 1'b0);
        end
        check_output("second_trip_hf", hf0, 1);

        // Debias stream 01,10,00,11,10,01,01,10,10,01 -> bits 0110_0110.
        en1 = 1'b1;
        tick();
        for (int i = 0; i <= 22; i++) begin
            raw1 = (i >= 2 && i <= 21) ? {3'b000, db_stream[21-i]} : 4'b0000;
            tick();
        end
        check_output("db_not_early", valid1, 0);
        check_output("db_no_health_fail", hf1, 0);
        raw1 = 4'b0000;
        tick();
        check_output("db_valid", valid1, 1);
        check_output("db_data", data1, 32'h66);
        check_output("fail_still_held", hf0, 1);

        // Asynchronous reset mid-cycle while dut1 is FULL and dut0 is in FAIL.
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async_valid", valid1, 0);
        check_output("async_trng_en", trng_en1, 0);
        check_output("async_data", data1, 0);
        check_output("async_health_fail", hf0, 0);
        #10;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
